brkpt_ctrl: RTL

- Sequencing controller in front of the four breakpoint address comparators.
- Adds per-breakpoint enables, pass counts (skip N matches before halting), arm/disarm control, sticky hit status, and a halt-request handshake with the CPU that re-pulses until acknowledged.
- Sits between the console register interface, the comparator match outputs and the CPU halt input.

---
 rtl/brkpt_pkg.sv | 24 ++
 rtl/brkpt_passcnt.sv | 45 ++++
 rtl/brkpt_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/brkpt_pkg.sv
// Shared definitions for the breakpoint sequencing controller:
// state encoding, console register map and control-word bit positions.
package brkpt_pkg;

    localparam int unsigned NUM_BRK_DEF   = 4;
    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned ADDR_W        = 3;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HALTREQ  = 2'd2,
        HALTED   = 2'd3
    } brk_state_e;

    localparam logic [ADDR_W-1:0] BR_EN    = 3'd0;
    localparam logic [ADDR_W-1:0] BR_CTL   = 3'd1;
    localparam logic [ADDR_W-1:0] BR_PASS0 = 3'd4;

    localparam int unsigned CTL_ARM    = 0;
    localparam int unsigned CTL_CLRHIT = 1;
    localparam int unsigned CTL_DISARM = 2;

endpackage

// File: rtl/brkpt_passcnt.sv
// One breakpoint's pass-count preset register and its down-counter.
// The counter reloads from the preset only on load; preset writes never disturb it.
module brkpt_passcnt
    import brkpt_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [CNT_WIDTH-1:0] wdata,
    input  logic                 load,
    input  logic                 dec,
    output logic                 zero_c
);

    logic [CNT_WIDTH-1:0] preset_q, preset_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        preset_d = preset_q;
        cnt_d    = cnt_q;
        if (wr) begin
            preset_d = wdata;
        end
        if (load) begin
            cnt_d = preset_q;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preset_q <= '0;
            cnt_q    <= '0;
        end else begin
            preset_q <= preset_d;
            cnt_q    <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/brkpt_ctrl.sv
// Breakpoint sequencer: qualifies comparator matches with enables and pass counts,
// keeps sticky hit flags and drives a re-pulsing halt request until the CPU acknowledges.
module brkpt_ctrl
    import brkpt_pkg::*;
#(
    parameter int unsigned NUM_BRK     = NUM_BRK_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpuCYC,
    input  logic [NUM_BRK-1:0]   brMATCH,
    input  logic                 cpuHALTACK,
    input  logic                 cslWR,
    input  logic [ADDR_W-1:0]    cslADDR,
    input  logic [CNT_WIDTH-1:0] cslDATA,
    output logic                 brHALT,
    output logic [NUM_BRK-1:0]   brHIT,
    output logic                 brARMED,
    output logic                 brPEND
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    brk_state_e state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [NUM_BRK-1:0] en_q, en_d;
    logic [NUM_BRK-1:0] hit_q, hit_d;
    logic               halt_q, halt_d;
    logic               armed_q, armed_d;
    logic               pend_q, pend_d;

    logic               ctl_wr_c, arm_c, clr_c, disarm_c;
    logic               load_c;
    logic [NUM_BRK-1:0] ev_c, dec_c, new_hit_c, zero_c, pass_wr_c;

    // Console register decode
    always_comb begin
        ctl_wr_c = cslWR && (cslADDR == BR_CTL);
        arm_c    = ctl_wr_c && cslDATA[CTL_ARM];
        clr_c    = ctl_wr_c && cslDATA[CTL_CLRHIT];
        disarm_c = ctl_wr_c && cslDATA[CTL_DISARM];
        en_d     = en_q;
        if (cslWR && (cslADDR == BR_EN)) begin
            en_d = cslDATA[NUM_BRK-1:0];
        end
        for (int unsigned i = 0; i < NUM_BRK; i++) begin
            pass_wr_c[i] = cslWR && (cslADDR == ADDR_W'(BR_PASS0 + ADDR_W'(i)));
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        halt_d    = 1'b0;
        load_c    = 1'b0;
        ev_c      = '0;
        dec_c     = '0;
        new_hit_c = '0;

        if (disarm_c) begin
            state_d = DISARMED;
            tmo_d   = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    if (arm_c) begin
                        state_d = ARMED;
                        load_c  = 1'b1;
                    end
                end
                ARMED: begin
                    if (arm_c) begin
                        // Reload takes priority; a coincident match is dropped
                        load_c = 1'b1;
                    end else begin
                        ev_c      = {NUM_BRK{cpuCYC}} & brMATCH & en_q;
                        new_hit_c = ev_c & zero_c;
                        dec_c     = ev_c & ~zero_c;
                        if (new_hit_c != '0) begin
                            state_d = HALTREQ;
                            halt_d  = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
                HALTREQ: begin
                    if (cpuHALTACK) begin
                        state_d = HALTED;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT)) begin
                        halt_d = 1'b1;
                        tmo_d  = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                HALTED: begin
                    if (arm_c) begin
                        state_d = ARMED;
                        load_c  = 1'b1;
                    end
                end
                default: begin
                    state_d = DISARMED;
                end
            endcase
        end

        hit_d   = (clr_c ? '0 : hit_q) | new_hit_c;
        armed_d = (state_d == ARMED);
        pend_d  = (state_d == HALTREQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISARMED;
            tmo_q   <= '0;
            en_q    <= '0;
            hit_q   <= '0;
            halt_q  <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            en_q    <= en_d;
            hit_q   <= hit_d;
            halt_q  <= halt_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_BRK; g++) begin : g_cnt
        brkpt_passcnt #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .wr    (pass_wr_c[g]),
            .wdata (cslDATA),
            .load  (load_c),
            .dec   (dec_c[g]),
            .zero_c(zero_c[g])
        );
    end

    assign brHALT  = halt_q;
    assign brHIT   = hit_q;
    assign brARMED = armed_q;
    assign brPEND  = pend_q;

endmodule
